// File: rtl/hcsr04_pkg.sv
// HC-SR04 shared timing constants, emulator state type and helpers.
// Used by both the sensor emulator and the capture side.
`timescale 1ns/1ps
package hcsr04_pkg;

  localparam int T_CLK_NS   = 10;
  localparam int TRIG_NS    = 10000;
  localparam int BURST_NS   = 200000;
  localparam int TIMEOUT_NS = 38000000;

  localparam int ECHO_W = 22;
  typedef logic [ECHO_W-1:0] echo_time_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRIG_HI,
    ST_BURST,
    ST_ECHO
  } emu_state_t;

  function automatic int ns_to_counts(
    input int ns,
    input int t_clk
  );
    return ns / t_clk;
  endfunction

endpackage

// File: rtl/hcsr04_sync_edge.sv
// 2-FF synchronizer with a third flop for rise/fall detection.
// Also suits the echo input of the capture block.
`timescale 1ns/1ps
module hcsr04_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic q1;
  logic q2;

  // Resynchronize the async input and keep one delayed copy for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q1   <= 1'b0;
      q2   <= 1'b0;
    end else begin
      meta <= din;
      q1   <= meta;
      q2   <= q1;
    end
  end

  assign level = q1;
  assign rise  = q1 & ~q2;
  assign fall  = q2 & ~q1;

endmodule

// File: rtl/hcsr04_emulator.sv
// Sensor-side HC-SR04 model: trigger in, burst delay, echo out.
// Optional echo-length jitter with macro HCSR04_EMU_JITTER_EN.
`timescale 1ns/1ps
module hcsr04_emulator
  import hcsr04_pkg::*;
#(
  parameter int T_CLK      = hcsr04_pkg::T_CLK_NS,
  parameter int TRIG_NS    = hcsr04_pkg::TRIG_NS,
  parameter int BURST_NS   = hcsr04_pkg::BURST_NS,
  parameter int TIMEOUT_NS = hcsr04_pkg::TIMEOUT_NS
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_trigger,
  input  echo_time_t i_echo_time,
  output logic       o_echo,
  output logic       o_busy,
  output logic       o_trig_err
);

  localparam int TRIG_C    = ns_to_counts(TRIG_NS, T_CLK);
  localparam int BURST_C   = ns_to_counts(BURST_NS, T_CLK);
  localparam int TIMEOUT_C = ns_to_counts(TIMEOUT_NS, T_CLK);

  localparam int WW = $clog2(TRIG_C + 1);
  localparam int BW = $clog2(BURST_C + 1);

  localparam logic [WW-1:0] TRIG_CW = WW'(TRIG_C);
  localparam logic [BW-1:0] B_LAST  = BW'(BURST_C - 1);
  localparam echo_time_t    TO_L    = echo_time_t'(TIMEOUT_C);

  if (TIMEOUT_C < 1 || TIMEOUT_C > (1 << ECHO_W) - 1) begin : g_to_chk
    $error("TIMEOUT_COUNTS must be in 1..2^22-1");
  end
  if (TRIG_C < 1 || BURST_C < 1) begin : g_cnt_chk
    $error("TRIG_COUNTS and BURST_COUNTS must be >= 1");
  end

  logic level;
  logic rise;
  logic fall;

  hcsr04_sync_edge u_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .din   (i_trigger),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  emu_state_t    state;
  logic [WW-1:0] wcnt;
  logic [BW-1:0] bcnt;
  echo_time_t    ecnt;
  echo_time_t    len;
  echo_time_t    len_next;

`ifdef HCSR04_EMU_JITTER_EN
  logic [15:0]       lfsr;
  logic              lfsr_fb;
  echo_time_t        base;
  logic [ECHO_W:0]   sum;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Free-running Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  // Base length plus 0..15 cycles of jitter, clamped after the add
  always_comb begin
    base     = (i_echo_time == '0) ? TO_L : i_echo_time;
    sum      = {1'b0, base} + (ECHO_W+1)'(lfsr[3:0]);
    len_next = (sum > {1'b0, TO_L}) ? TO_L : sum[ECHO_W-1:0];
  end
`else
  // Zero means no object; anything beyond the timeout is clamped
  always_comb begin
    len_next = i_echo_time;
    if (i_echo_time == '0 || i_echo_time > TO_L) begin
      len_next = TO_L;
    end
  end
`endif

  // Protocol FSM with registered echo, busy and error outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      wcnt       <= '0;
      bcnt       <= '0;
      ecnt       <= '0;
      len        <= '0;
      o_echo     <= 1'b0;
      o_busy     <= 1'b0;
      o_trig_err <= 1'b0;
    end else begin
      o_trig_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rise) begin
            wcnt  <= WW'(1);
            state <= ST_TRIG_HI;
          end
        end
        ST_TRIG_HI: begin
          if (fall) begin
            wcnt <= '0;
            if (wcnt >= TRIG_CW) begin
              len    <= len_next;
              bcnt   <= '0;
              o_busy <= 1'b1;
              state  <= ST_BURST;
            end else begin
              o_trig_err <= 1'b1;
              state      <= ST_IDLE;
            end
          end else if (level && wcnt < TRIG_CW) begin
            wcnt <= wcnt + WW'(1);
          end
        end
        ST_BURST: begin
          if (bcnt == B_LAST) begin
            bcnt   <= '0;
            ecnt   <= '0;
            o_echo <= 1'b1;
            state  <= ST_ECHO;
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        ST_ECHO: begin
          if (ecnt == len - echo_time_t'(1)) begin
            ecnt   <= '0;
            o_echo <= 1'b0;
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            ecnt <= ecnt + echo_time_t'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
